// File: rtl/adder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adder_pkg
// Purpose  : Shared definitions for the pipelined add/subtract unit:
//            default geometry, the WIDTH/CHUNK legality check and the
//            signed-overflow rule used by the last pipeline stage.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package adder_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_CHUNK = 8;

  // True when WIDTH splits into a whole number (>= 1) of CHUNK-bit slices.
  function automatic bit chunk_legal(input int width, input int chunk);
    return (chunk > 0) && (width >= chunk) && ((width % chunk) == 0);
  endfunction

  // Two's-complement overflow: carry into the MSB differs from carry out.
  function automatic logic signed_overflow(input logic c_msb_in, input logic c_msb_out);
    return c_msb_in ^ c_msb_out;
  endfunction

endpackage
`default_nettype wire

// File: rtl/adder_chunk.sv
`default_nettype none
// ============================================================================
// Module   : adder_chunk
// Purpose  : Combinational CHUNK-bit adder slice used by every pipeline
//            stage of adder_pipe.
// Ports    : a, b      - CHUNK-bit operand slices
//            cin       - carry in from the previous slice
//            sum       - CHUNK-bit slice result
//            cout      - carry out of the slice MSB
//            c_msb_in  - carry into the slice MSB (for overflow detection)
// Revision : 1.0 - initial release
// ============================================================================
module adder_chunk
  import adder_pkg::*;
#(
  parameter int CHUNK = DEFAULT_CHUNK
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb_in
);

  logic [CHUNK:0] full;

  assign full = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
  assign sum  = full[CHUNK-1:0];
  assign cout = full[CHUNK];

  // The MSB sum bit is a ^ b ^ carry_in at that position, so the carry into
  // the MSB can be recovered without a second adder.
  assign c_msb_in = a[CHUNK-1] ^ b[CHUNK-1] ^ full[CHUNK-1];

endmodule
`default_nettype wire

// File: rtl/adder_pipe.sv
`default_nettype none
// ============================================================================
// Module   : adder_pipe
// Purpose  : Pipelined WIDTH-bit add/subtract unit. The carry chain is cut
//            into CHUNK-bit slices with one register stage per slice
//            (skewed pipeline), wrapped in valid/ready handshakes.
// Ports    : clk, rst_n           - clock, async active-low reset
//            in_valid / in_ready  - operand handshake
//            a, b, sub            - operands; sub=1 selects a-b
//            out_valid / out_ready- result handshake
//            sum, carry, overflow - result, MSB carry-out, signed overflow
// Revision : 1.0 - initial release
// ============================================================================
module adder_pipe
  import adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CHUNK = DEFAULT_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  localparam int STAGES = WIDTH / CHUNK;

  if (!chunk_legal(WIDTH, CHUNK)) begin : g_param_check
    $error("adder_pipe: WIDTH (%0d) must be a positive multiple of CHUNK (%0d)", WIDTH, CHUNK);
  end

  // The whole pipeline moves in lock-step: it advances whenever the output
  // slot is empty or is being drained this cycle.
  logic             adv;
  logic [WIDTH-1:0] b_eff;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Subtraction as a + ~b + 1; the +1 enters as the stage-0 carry.
  assign b_eff = sub ? ~b : b;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int IN_W = WIDTH - k * CHUNK;   // operand bits still unprocessed
    localparam int LO_W = (k + 1) * CHUNK;     // result bits known after this stage

    logic [IN_W-1:0]  a_in;
    logic [IN_W-1:0]  b_in;
    logic             cin_k;
    logic             vin;
    logic [CHUNK-1:0] s;
    logic             co;
    logic             c_msb;
    logic [LO_W-1:0]  lo_next;

    logic             v_r;
    logic             c_r;
    logic [LO_W-1:0]  lo_r;

    if (k == 0) begin : g_head
      assign a_in    = a;
      assign b_in    = b_eff;
      assign cin_k   = sub;
      assign vin     = in_valid;
      assign lo_next = s;
    end else begin : g_body
      assign a_in    = g_stage[k-1].g_hi.a_r;
      assign b_in    = g_stage[k-1].g_hi.b_r;
      assign cin_k   = g_stage[k-1].c_r;
      assign vin     = g_stage[k-1].v_r;
      assign lo_next = {s, g_stage[k-1].lo_r};
    end

    adder_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a        (a_in[CHUNK-1:0]),
      .b        (b_in[CHUNK-1:0]),
      .cin      (cin_k),
      .sum      (s),
      .cout     (co),
      .c_msb_in (c_msb)
    );

    // Data registers only load with a real beat, so bubbles leave the last
    // result visible on sum/carry/overflow.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_r  <= 1'b0;
        c_r  <= 1'b0;
        lo_r <= '0;
      end else if (adv) begin
        v_r <= vin;
        if (vin) begin
          c_r  <= co;
          lo_r <= lo_next;
        end
      end
    end

    if (k < STAGES - 1) begin : g_hi
      // Upper operand slices travel alongside the beat until their stage.
      logic [IN_W-CHUNK-1:0] a_r;
      logic [IN_W-CHUNK-1:0] b_r;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_r <= '0;
          b_r <= '0;
        end else if (adv && vin) begin
          a_r <= a_in[IN_W-1:CHUNK];
          b_r <= b_in[IN_W-1:CHUNK];
        end
      end
    end else begin : g_tail
      logic ov_r;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ov_r <= 1'b0;
        end else if (adv && vin) begin
          ov_r <= signed_overflow(c_msb, co);
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].v_r;
  assign sum       = g_stage[STAGES-1].lo_r;
  assign carry     = g_stage[STAGES-1].c_r;
  assign overflow  = g_stage[STAGES-1].g_tail.ov_r;

endmodule
`default_nettype wire

// File: tb/tb_adder_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_adder_pipe
// Purpose  : Self-checking bench for adder_pipe in three geometries
//            (32/8, 8/8, 16/4): directed vector table, back-to-back,
//            stall, reset-flush and randomized handshake streams against
//            an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adder_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // cfg 0: WIDTH=32 CHUNK=8
  logic        in_valid0, in_ready0, sub0, out_valid0, out_ready0, carry0, ovf0;
  logic [31:0] a0, b0, sum0;
  // cfg 1: WIDTH=8 CHUNK=8
  logic        in_valid1, in_ready1, sub1, out_valid1, out_ready1, carry1, ovf1;
  logic [7:0]  a1, b1, sum1;
  // cfg 2: WIDTH=16 CHUNK=4
  logic        in_valid2, in_ready2, sub2, out_valid2, out_ready2, carry2, ovf2;
  logic [15:0] a2, b2, sum2;

  adder_pipe #(.WIDTH(32), .CHUNK(8)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
    .a(a0), .b(b0), .sub(sub0), .out_valid(out_valid0), .out_ready(out_ready0),
    .sum(sum0), .carry(carry0), .overflow(ovf0));

  adder_pipe #(.WIDTH(8), .CHUNK(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .sub(sub1), .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .carry(carry1), .overflow(ovf1));

  adder_pipe #(.WIDTH(16), .CHUNK(4)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .b(b2), .sub(sub2), .out_valid(out_valid2), .out_ready(out_ready2),
    .sum(sum2), .carry(carry2), .overflow(ovf2));

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int          cfg;
    logic [31:0] a;
    logic [31:0] b;
    bit          s;
    logic [31:0] e_sum;
    bit          e_c;
    bit          e_o;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int width_of(input int cfg);
    case (cfg)
      0:       return 32;
      1:       return 8;
      default: return 16;
    endcase
  endfunction

  function automatic int stages_of(input int cfg);
    case (cfg)
      0:       return 4;
      1:       return 1;
      default: return 4;
    endcase
  endfunction

  // Reference: plain integer arithmetic on unsigned and signed readings.
  function automatic logic [33:0] model(input int w, input logic [31:0] a, input logic [31:0] b, input bit s);
    longint full, half, ua, ub, sa, sb, r_u, r_s;
    bit c, o;
    logic [63:0] r_bits;
    full = longint'(1) << w;
    half = full / 2;
    ua = longint'(a) & (full - 1);
    ub = longint'(b) & (full - 1);
    sa = (ua >= half) ? ua - full : ua;
    sb = (ub >= half) ? ub - full : ub;
    if (s) begin
      r_u = ua - ub;
      r_s = sa - sb;
      c   = (ua >= ub);
    end else begin
      r_u = ua + ub;
      r_s = sa + sb;
      c   = (r_u >= full);
    end
    o = (r_s < -half) || (r_s >= half);
    r_u = ((r_u % full) + full) % full;
    r_bits = r_u;
    return {o, c, r_bits[31:0]};
  endfunction

  task automatic drive(input int cfg, input bit v, input logic [31:0] a, input logic [31:0] b, input bit s);
    case (cfg)
      0: begin in_valid0 = v; a0 = a;       b0 = b;       sub0 = s; end
      1: begin in_valid1 = v; a1 = a[7:0];  b1 = b[7:0];  sub1 = s; end
      default: begin in_valid2 = v; a2 = a[15:0]; b2 = b[15:0]; sub2 = s; end
    endcase
  endtask

  task automatic set_ready(input int cfg, input bit r);
    case (cfg)
      0: out_ready0 = r;
      1: out_ready1 = r;
      default: out_ready2 = r;
    endcase
  endtask

  function automatic bit get_in_ready(input int cfg);
    case (cfg)
      0: return in_ready0;
      1: return in_ready1;
      default: return in_ready2;
    endcase
  endfunction

  function automatic bit get_out_valid(input int cfg);
    case (cfg)
      0: return out_valid0;
      1: return out_valid1;
      default: return out_valid2;
    endcase
  endfunction

  function automatic logic [33:0] get_result(input int cfg);
    case (cfg)
      0: return {ovf0, carry0, sum0};
      1: return {ovf1, carry1, 24'h0, sum1};
      default: return {ovf2, carry2, 16'h0, sum2};
    endcase
  endfunction

  // Single beat with out_ready=1: checks latency and the three outputs.
  task automatic run_vec(input int cfg, input logic [31:0] a, input logic [31:0] b, input bit s,
                         input logic [31:0] e_sum, input bit e_c, input bit e_o, input string name);
    int cyc;
    logic [33:0] r;
    set_ready(cfg, 1'b1);
    @(negedge clk);
    check({name, " in_ready"}, get_in_ready(cfg), 1);
    drive(cfg, 1'b1, a, b, s);
    @(posedge clk);
    #1;
    drive(cfg, 1'b0, 32'h0, 32'h0, 1'b0);
    cyc = 1;
    while (!get_out_valid(cfg) && cyc < stages_of(cfg) + 4) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check({name, " latency"}, cyc, stages_of(cfg));
    r = get_result(cfg);
    check({name, " sum"}, r[31:0], e_sum);
    check({name, " carry"}, r[32], e_c);
    check({name, " overflow"}, r[33], e_o);
  endtask

  task automatic random_stream(input int cfg, input int n);
    logic [33:0] q[$];
    logic [33:0] e;
    logic [31:0] ra, rb;
    bit rs, v, rdy;
    int sent, got;
    sent = 0; got = 0; v = 1'b0; ra = '0; rb = '0; rs = 1'b0;
    for (int cyc = 0; cyc < n * 10 + 50 && got < n; cyc++) begin
      @(posedge clk);
      #1;
      if (!v && sent < n && $urandom_range(3) != 0) begin
        v  = 1'b1;
        ra = $urandom;
        rb = $urandom;
        rs = bit'($urandom_range(1));
      end
      rdy = ($urandom_range(2) != 0);
      drive(cfg, v, ra, rb, rs);
      set_ready(cfg, rdy);
      @(negedge clk);
      if (v && get_in_ready(cfg)) begin
        q.push_back(model(width_of(cfg), ra, rb, rs));
        sent++;
        v = 1'b0;
      end
      if (get_out_valid(cfg) && rdy) begin
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL rand cfg%0d spurious result: got 0x%0h, expected no beat", cfg, get_result(cfg));
        end else begin
          e = q.pop_front();
          check($sformatf("rand cfg%0d beat %0d", cfg, got), get_result(cfg), e);
          got++;
        end
      end
    end
    check($sformatf("rand cfg%0d beats delivered", cfg), got, n);
    drive(cfg, 1'b0, 32'h0, 32'h0, 1'b0);
    set_ready(cfg, 1'b1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int c = 0; c < 3; c++) begin
      drive(c, 1'b0, 32'h0, 32'h0, 1'b0);
      set_ready(c, 1'b1);
    end

    // Directed vectors, expected values worked out by hand.
    vecs.push_back('{0, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0, "w32 0+0"});
    vecs.push_back('{0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, "w32 ripple"});
    vecs.push_back('{0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, "w32 add ovf"});
    vecs.push_back('{0, 32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, "w32 5-7"});
    vecs.push_back('{0, 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, "w32 sub ovf"});
    vecs.push_back('{1, 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, "w8 ripple"});
    vecs.push_back('{1, 32'h0000_007F, 32'h0000_0001, 1'b0, 32'h0000_0080, 1'b0, 1'b1, "w8 add ovf"});
    vecs.push_back('{1, 32'h0000_0005, 32'h0000_0007, 1'b1, 32'h0000_00FE, 1'b0, 1'b0, "w8 5-7"});
    vecs.push_back('{1, 32'h0000_0080, 32'h0000_0001, 1'b1, 32'h0000_007F, 1'b1, 1'b1, "w8 sub ovf"});
    vecs.push_back('{2, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, "w16 ripple"});
    vecs.push_back('{2, 32'h0000_7FFF, 32'h0000_0001, 1'b0, 32'h0000_8000, 1'b0, 1'b1, "w16 add ovf"});
    vecs.push_back('{2, 32'h0000_0005, 32'h0000_0007, 1'b1, 32'h0000_FFFE, 1'b0, 1'b0, "w16 5-7"});
    vecs.push_back('{2, 32'h0000_8000, 32'h0000_0001, 1'b1, 32'h0000_7FFF, 1'b1, 1'b1, "w16 sub ovf"});

    // Reset state while held in reset.
    repeat (3) @(posedge clk);
    #1;
    for (int c = 0; c < 3; c++) begin
      check($sformatf("reset cfg%0d out_valid", c), get_out_valid(c), 0);
      check($sformatf("reset cfg%0d in_ready", c), get_in_ready(c), 1);
      check($sformatf("reset cfg%0d result", c), get_result(c), 34'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i])
      run_vec(vecs[i].cfg, vecs[i].a, vecs[i].b, vecs[i].s,
              vecs[i].e_sum, vecs[i].e_c, vecs[i].e_o, vecs[i].name);

    // Back-to-back beats: results on four consecutive cycles, in order.
    begin : t_b2b
      logic [31:0] ba[4], bb[4], es[4];
      bit bs[4], ec[4];
      int t;
      ba = '{32'h55, 32'hAA, 32'h10, 32'hFF};
      bb = '{32'h33, 32'hAA, 32'h01, 32'h01};
      bs = '{1'b0, 1'b0, 1'b1, 1'b0};
      es = '{32'h88, 32'h154, 32'h0F, 32'h100};
      ec = '{1'b0, 1'b0, 1'b1, 1'b0};
      set_ready(0, 1'b1);
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        drive(0, 1'b1, ba[i], bb[i], bs[i]);
        @(posedge clk);
        #1;
      end
      drive(0, 1'b0, 32'h0, 32'h0, 1'b0);
      t = 0;
      while (!out_valid0 && t < 10) begin
        @(posedge clk);
        #1;
        t++;
      end
      for (int i = 0; i < 4; i++) begin
        check($sformatf("b2b beat %0d valid", i), out_valid0, 1);
        check($sformatf("b2b beat %0d sum", i), sum0, es[i]);
        check($sformatf("b2b beat %0d carry", i), carry0, ec[i]);
        @(posedge clk);
        #1;
      end
    end

    // Stall: out_ready low for 5 cycles after the first result.
    begin : t_stall
      logic [33:0] q[$];
      logic [33:0] e;
      logic [31:0] sa_[6], sb_[6];
      bit ss_[6];
      bit started, rdy;
      int sent, got, stall;
      for (int i = 0; i < 6; i++) begin
        sa_[i] = 32'h1111_1111 * (i + 1);
        sb_[i] = 32'h0101_0101 + 32'h0F0F * i;
        ss_[i] = (i % 2) == 1;
      end
      sent = 0; got = 0; stall = 0; started = 1'b0;
      for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
        @(posedge clk);
        #1;
        if (started && stall < 5) begin
          rdy = 1'b0;
          stall++;
        end else begin
          rdy = 1'b1;
        end
        set_ready(0, rdy);
        if (sent < 6) drive(0, 1'b1, sa_[sent], sb_[sent], ss_[sent]);
        else          drive(0, 1'b0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        if (!rdy) begin
          check($sformatf("stall %0d in_ready", stall), in_ready0, 0);
          check($sformatf("stall %0d out_valid", stall), out_valid0, 1);
          if (q.size() > 0)
            check($sformatf("stall %0d held result", stall), {ovf0, carry0, sum0}, q[0]);
        end
        if (sent < 6 && in_ready0) begin
          q.push_back(model(32, sa_[sent], sb_[sent], ss_[sent]));
          sent++;
        end
        if (out_valid0 && rdy) begin
          if (q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL stall spurious result: got 0x%0h, expected no beat", sum0);
          end else begin
            e = q.pop_front();
            check($sformatf("stall beat %0d", got), {ovf0, carry0, sum0}, e);
            got++;
            started = 1'b1;
          end
        end
      end
      check("stall beats delivered", got, 6);
      drive(0, 1'b0, 32'h0, 32'h0, 1'b0);
      set_ready(0, 1'b1);
    end

    // Reset with three beats in flight flushes them all.
    begin : t_reset
      int spurious;
      set_ready(0, 1'b1);
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
        drive(0, 1'b1, 32'h100 + i, 32'h1, 1'b0);
        @(posedge clk);
        #1;
      end
      drive(0, 1'b0, 32'h0, 32'h0, 1'b0);
      @(posedge clk);
      #1;
      check("pre-reset first beat valid", out_valid0, 1);
      check("pre-reset first beat sum", sum0, 32'h101);
      #2;
      rst_n = 1'b0;
      #1;
      check("async reset out_valid", out_valid0, 0);
      check("async reset result", {ovf0, carry0, sum0}, 34'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      spurious = 0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (out_valid0) spurious++;
      end
      check("post-reset stale beats", spurious, 0);
      run_vec(0, 32'd3, 32'd4, 1'b0, 32'd7, 1'b0, 1'b0, "post-reset 3+4");
    end

    random_stream(0, 150);
    random_stream(1, 150);
    random_stream(2, 150);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
